// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, PC step and default addresses for the fetch sequencer
package pc_seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, HALTED} state_t;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority mux choosing the next PC (reset/idle, halted hold, exception, redirect, +4, hold)
//   reset, state, pc, imem_ack   : sequencer context
//   redirect_valid/target        : resolved control transfer, target word-aligned here
//   exc_take                     : exception accepted this cycle
//   npc                          : value the PC register loads at the next edge
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        reset,
    input  state_t      state,
    input  logic [31:0] pc,
    input  logic        imem_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_take,
    output logic [31:0] npc
);
    always_comb begin
        npc = (reset || state == IDLE) ? RESET_PC :
              (state == HALTED)        ? pc :
              exc_take                 ? EXC_VECTOR :
              redirect_valid           ? word_align(redirect_target) :
              (state == FETCH && imem_ack) ? pc + PC_STEP : pc;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side controller sequencing the PC register, issuing fetches and buffering instructions
//   clk, reset                   : clock and synchronous active-high reset
//   pc / npc                     : current and next PC-register value
//   imem_req/addr/ack/rdata      : instruction-memory request and response
//   if_valid/instr/pc/ready      : buffered instruction handshake to decode
//   redirect_valid/target, halt  : control-transfer and stop requests
//   exc_req / epc                : exception request and captured PC (active only with PC_SEQ_EXC_EN)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    input  logic        exc_req,
    output logic [31:0] epc
);
    state_t state;
    logic exc_take;
    logic jump;
`ifdef PC_SEQ_EXC_EN
    assign exc_take = exc_req && state != IDLE && state != HALTED;
`else
    logic unused_exc;
    assign exc_take = 1'b0;
    assign unused_exc = exc_req;
`endif
    assign jump = exc_take || redirect_valid;
    assign imem_addr = pc;

    pc_next_sel #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) u_sel (
        .reset(reset),
        .state(state),
        .pc(pc),
        .imem_ack(imem_ack),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .exc_take(exc_take),
        .npc(npc)
    );

    // imem_req is registered alongside the state so it is high exactly while in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            epc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (jump) begin
                        // a same-cycle ack completes the stale fetch; otherwise wait for it in DRAIN
                        state    <= imem_ack ? FETCH : DRAIN;
                        imem_req <= imem_ack;
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end
                end
                HOLD: begin
                    if (jump) begin
                        if_valid <= 1'b0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= halt ? HALTED : FETCH;
                        imem_req <= !halt;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef PC_SEQ_EXC_EN
            if (exc_take) epc <= if_valid ? if_pc : pc;
`endif
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a scoreboard queue checked by an independent decode-side monitor
module tb_pc_sequencer;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
`ifdef PC_SEQ_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt = 1'b0;
    logic        exc_req = 1'b0;
    logic [31:0] epc;
    int errors = 0;
    int checks = 0;
    exp_t q[$];
    logic [31:0] cur;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc(pc), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .exc_req(exc_req), .epc(epc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc <= npc;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask

    // decode side: every accepted instruction must match the oldest expected fetch
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #4;
        if (!reset && if_valid && if_ready && !redirect_valid && !(EXC && exc_req)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver: got pc %h instr %h, required nothing", if_pc, if_instr);
            end else begin
                e = q.pop_front();
                chk("deliver_pc", if_pc, e.pc);
                chk("deliver_instr", if_instr, e.instr);
            end
        end
    end

    // called at a FETCH negedge; returns at the following HOLD negedge
    task automatic fetch_ack(input logic [31:0] a, input logic [31:0] d, input bit keep);
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, a);
        imem_ack = 1'b1;
        imem_rdata = d;
        if (keep) q.push_back('{pc: a, instr: d});
        #1 chk("npc_inc", npc, a + 32'd4);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = '0;
        #1;
        chk("hold_req", imem_req, 0);
        chk("hold_valid", if_valid, 1);
        chk("pc_adv", pc, a + 32'd4);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", if_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_ifpc", if_pc, 0);
        chk("rst_epc", epc, 0);
        chk("rst_npc", npc, 0);
        reset = 1'b0;
        #1 chk("idle_npc", npc, 0);
        chk("idle_req", imem_req, 0);
        @(negedge clk);
        fetch_ack(32'h0, 32'hA000_0000, 1);
        @(negedge clk);
        fetch_ack(32'h4, 32'hA000_0001, 1);
        @(negedge clk);
        fetch_ack(32'h8, 32'hA000_0002, 1);
        @(negedge clk);
        if_ready = 1'b0;
        fetch_ack(32'hC, 32'hB000_0000, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", if_valid, 1);
            chk("stall_pc", if_pc, 32'hC);
            chk("stall_instr", if_instr, 32'hB000_0000);
            chk("stall_req", imem_req, 0);
            chk("stall_npc", npc, 32'h10);
            @(negedge clk);
        end
        if_ready = 1'b1;
        @(negedge clk);
        chk("fetch10_addr", imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_1002;
        #1 chk("redir_npc", npc, 32'h1000);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1 chk("drain_req", imem_req, 0);
        chk("drain_pc", pc, 32'h1000);
        chk("drain_npc", npc, 32'h1000);
        repeat (2) @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1 chk("drain_ack_npc", npc, 32'h1000);
        @(negedge clk);
        imem_ack = 1'b0;
        #1 chk("post_drain_valid", if_valid, 0);
        fetch_ack(32'h1000, 32'hC000_0000, 1);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        #1 chk("ackredir_npc", npc, 32'h300);
        @(negedge clk);
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        #1 chk("ackredir_valid", if_valid, 0);
        fetch_ack(32'h300, 32'hD000_0000, 0);
        redirect_valid = 1'b1;
        redirect_target = 32'h2002;
        halt = 1'b1;
        #1 chk("redirhalt_npc", npc, 32'h2000);
        @(negedge clk);
        redirect_valid = 1'b0;
        halt = 1'b0;
        #1 chk("redirhalt_valid", if_valid, 0);
        fetch_ack(32'h2000, 32'hD000_0001, 0);
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        #1 chk("mask_npc", npc, 32'hFFFF_FFFC);
        @(negedge clk);
        redirect_valid = 1'b0;
        fetch_ack(32'hFFFF_FFFC, 32'hE000_0000, 1);
        chk("wrap_pc", pc, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        #1;
        @(negedge clk);
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        fetch_ack(32'h20, 32'hF000_0000, !EXC);
`ifdef PC_SEQ_EXC_EN
        exc_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        #1 chk("exc_npc", npc, 32'h180);
        @(negedge clk);
        exc_req = 1'b0;
        redirect_valid = 1'b0;
        #1 chk("exc_epc", epc, 32'h20);
        chk("exc_valid", if_valid, 0);
        chk("exc_addr", imem_addr, 32'h180);
        cur = 32'h180;
`else
        exc_req = 1'b1;
        if_ready = 1'b0;
        #1 chk("noexc_npc", npc, 32'h24);
        @(negedge clk);
        exc_req = 1'b0;
        #1 chk("noexc_valid", if_valid, 1);
        chk("noexc_epc", epc, 0);
        chk("noexc_ifpc", if_pc, 32'h20);
        if_ready = 1'b1;
        @(negedge clk);
        cur = 32'h24;
`endif
        fetch_ack(cur, 32'h6000_0000, 1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            redirect_valid = 1'b1;
            redirect_target = 32'h500;
            exc_req = 1'b1;
            #1 chk("halted_npc", npc, cur + 32'd4);
            chk("halted_req", imem_req, 0);
            chk("halted_valid", if_valid, 0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        exc_req = 1'b0;
        reset = 1'b1;
        #1 chk("rst2_npc", npc, 0);
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1;
        #1 chk("idle_ack_npc", npc, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1 chk("idle_ack_valid", if_valid, 0);
        chk("rst2_epc", epc, 0);
        fetch_ack(32'h0, 32'h7000_0000, 1);
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Fetch-side controller that sequences the program-counter register.
- Every cycle it computes `npc` for the PC register: hold, +4, redirect target, or exception vector.
- It issues instruction-memory requests and buffers each returned instruction for decode with a valid/ready handshake.
- It discards fetches made stale by a branch, jump, or jr redirect.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `EXC_VECTOR`, default 32'h0000_0180: exception target. Used only with `PC_SEQ_EXC_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `pc`, in, 32: current PC-register value.
- `npc`, out, 32: next PC. The PC register loads it every clock.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address, always equal to `pc`.
- `imem_ack`, in, 1: response valid. Any latency ≥0 cycles.
- `imem_rdata`, in, 32: instruction word, valid with `imem_ack`.
- `if_valid`, out, 1: buffered instruction available.
- `if_instr`, out, 32: buffered instruction.
- `if_pc`, out, 32: address of `if_instr`.
- `if_ready`, in, 1: decode accepts the instruction.
- `redirect_valid`, in, 1: resolved taken branch, jump, or jr.
- `redirect_target`, in, 32: redirect address. Bits [1:0] are forced to 0.
- `halt`, in, 1: stop fetching after the current instruction.
- `exc_req`, in, 1: exception request.
- `epc`, out, 32: captured exception PC.

## Operation
States: IDLE, FETCH, HOLD, DRAIN, HALTED.
- Default `npc` is `pc` (hold). `imem_req` is 1 only in FETCH.
- **IDLE:** `npc`=`RESET_PC`. Go to FETCH.
- **FETCH, `imem_ack`=1:**
  - `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1.
  - `npc`=`pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Go to HOLD.
- **FETCH, `imem_ack`=0:** stay in FETCH.
- **HOLD:** `if_valid`=1 and the outputs are stable until `if_valid & if_ready`.
  - On handshake: `if_valid`<=0. Go to HALTED if `halt`=1, else FETCH.
- **Redirect** (`redirect_valid`=1, any state except IDLE/HALTED):
  - `npc`=target, with bits [1:0]=0.
  - From FETCH without ack: go to DRAIN.
  - From FETCH with ack in the same cycle: discard the response, go to FETCH.
  - From HOLD: `if_valid`<=0 (buffer dropped, even if `if_ready` is high that cycle), go to FETCH.
  - In DRAIN: retarget, stay in DRAIN.
- **DRAIN:** `imem_req`=0. The next `imem_ack` is discarded; go to FETCH.
- **HALTED:** `npc`=`pc`, no requests, ignores all inputs. Exited only by `reset`.
- **Priority:** `exc_req` (when enabled) > `redirect_valid` > `halt` > normal sequencing.
- **Reset:**
  - Drives `npc`=`RESET_PC` and next state IDLE.
  - Outputs reset to: `imem_req`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `epc`=0.
  - Reset mid-fetch abandons the request. An `imem_ack` arriving in IDLE is ignored.

## Timing
- First request: two clocks after reset deasserts (IDLE, then FETCH with `pc`=`RESET_PC`).
- `imem_ack` in cycle N: `if_valid`=1 in N+1, and `pc` advanced by 4 in N+1.
- Peak throughput: one instruction per 2 cycles (FETCH, HOLD) with zero-latency memory and `if_ready` tied high.
- Redirect in cycle N: `pc`=target in N+1. The new request starts in N+1, or after the DRAIN ack.
- All outputs except `npc` and `imem_addr` are registered.

## Configuration
`PC_SEQ_EXC_EN` compiles in exception handling.

When defined:
- `exc_req` is treated as a redirect to `EXC_VECTOR` from any non-IDLE, non-HALTED state.
- `epc`<=`if_pc` if `if_valid`, else `pc`.
- It beats a same-cycle `redirect_valid`.

When undefined:
- `exc_req` is ignored and `epc` is constant 0.
- Ports stay present.

## Structure
- Package `pc_seq_pkg` holds:
  - the state enum;
  - `PC_STEP`=4;
  - default `RESET_PC` and `EXC_VECTOR` constants.
- Sub-module `pc_next_sel`: combinational priority mux for `npc` and the alignment mask.

## Test plan
- **Reset, then zero-latency ack, `if_ready`=1:**
  - `imem_addr` 0x0, 0x4, 0x8 on alternate cycles.
  - `if_pc` follows with one cycle lag.
- **`if_ready`=0 for 5 cycles in HOLD:**
  - `if_instr` and `if_pc` stable, `imem_req`=0, `npc`=`pc`.
- **Redirect to 0x0000_1002 while FETCH waits (ack 3 cycles later):**
  - DRAIN entered; that ack is not presented to decode.
  - Next request goes to 0x0000_1000.
- **Redirect and `halt` in the same HOLD cycle:**
  - Buffer dropped, fetch resumes at the target, no HALTED.
- **`pc`=0xFFFF_FFFC with ack:** `npc`=0x0000_0000.
- **`PC_SEQ_EXC_EN` build, `exc_req` together with redirect to 0x40 while `if_pc`=0x20 is valid:**
  - `npc`=0x180 and `epc`=0x20.
